// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit framer and its CRC engine.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE    = 8'h55;
  localparam logic [7:0]  SFD_BYTE    = 8'hD5;
  localparam logic [31:0] CRC_SEED    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam int          MIN_PAYLOAD = 60;

  // One byte of the reflected CRC-32, consuming the byte LSB first.
  function automatic logic [31:0] crcUpdate(input logic [31:0] crcIn, input logic [7:0] dataIn);
    logic [31:0] acc;
    acc = crcIn ^ {24'h0, dataIn};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC_POLY) : (acc >> 1);
    end
    return acc;
  endfunction

endpackage

// File: rtl/eth_fcs_lfsr.sv
// Registered byte-wide reflected CRC-32; crc reflects a byte the cycle after en.
module eth_fcs_lfsr
  import eth_pkg::*;
(
  input  logic        c,
  input  logic        r,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      crc <= CRC_SEED;
    end else if (init) begin
      crc <= CRC_SEED;
    end else if (en) begin
      crc <= crcUpdate(crc, d);
    end
  end

endmodule

// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble, SFD, payload, optional pad, FCS and IFG.
// Minimum-length zero padding is built only when ETH_TX_PAD_EN is defined.
module eth_tx_framer
  import eth_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_LEN    = 1514
) (
  input  logic       c,
  input  logic       r,
  input  logic [7:0] d,
  input  logic       dv,
  input  logic       last,
  output logic       rdy,
  output logic [7:0] txd,
  output logic       txen,
  output logic       busy,
  output logic       err
);

  localparam int                IFG_W    = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0]  IFG_LAST = IFG_W'(IFG_CYCLES - 1);
  localparam logic [10:0]       LAST_IDX = 11'(MAX_LEN - 1);

  state_t           r_state, w_nextState;
  logic [2:0]       r_preCnt, w_nextPreCnt;
  logic [10:0]      r_byteCnt, w_nextByteCnt, w_incCnt;
  logic [1:0]       r_fcsCnt, w_nextFcsCnt;
  logic [IFG_W-1:0] r_ifgCnt, w_nextIfgCnt;
  logic [7:0]       w_nextTxd, w_fcsByte, w_crcData;
  logic             w_nextTxen, w_nextBusy, w_nextErr, w_nextRdy;
  logic             w_crcInit, w_crcEn, w_forcedLast;
  logic [31:0]      w_crc;

  eth_fcs_lfsr u_fcs (
    .c    (c),
    .r    (r),
    .init (w_crcInit),
    .en   (w_crcEn),
    .d    (w_crcData),
    .crc  (w_crc)
  );

  assign w_incCnt     = (r_byteCnt == 11'h7FF) ? r_byteCnt : r_byteCnt + 11'd1;
  assign w_forcedLast = (r_byteCnt == LAST_IDX);

  // The CRC register is frozen during FCS, so its bytes can be muxed out in turn.
  always_comb begin
    w_fcsByte = ~w_crc[7:0];
    case (r_fcsCnt)
      2'd1:    w_fcsByte = ~w_crc[15:8];
      2'd2:    w_fcsByte = ~w_crc[23:16];
      2'd3:    w_fcsByte = ~w_crc[31:24];
      default: w_fcsByte = ~w_crc[7:0];
    endcase
  end

  always_comb begin
    w_nextState   = r_state;
    w_nextPreCnt  = r_preCnt;
    w_nextByteCnt = r_byteCnt;
    w_nextFcsCnt  = r_fcsCnt;
    w_nextIfgCnt  = r_ifgCnt;
    w_nextTxd     = 8'h00;
    w_nextTxen    = 1'b0;
    w_nextBusy    = busy;
    w_nextErr     = 1'b0;
    w_crcInit     = 1'b0;
    w_crcEn       = 1'b0;
    w_crcData     = d;

    case (r_state)
      ST_IDLE: begin
        w_crcInit     = 1'b1;
        w_nextByteCnt = '0;
        if (dv) begin
          w_nextState  = ST_PRE;
          w_nextPreCnt = '0;
          w_nextTxd    = PREAMBLE;
          w_nextTxen   = 1'b1;
          w_nextBusy   = 1'b1;
        end
      end

      ST_PRE: begin
        w_crcInit     = 1'b1;
        w_nextByteCnt = '0;
        w_nextTxen    = 1'b1;
        if (r_preCnt == 3'd6) begin
          w_nextState = ST_SFD;
          w_nextTxd   = SFD_BYTE;
        end else begin
          w_nextPreCnt = r_preCnt + 3'd1;
          w_nextTxd    = PREAMBLE;
        end
      end

      // rdy is high here; a missing byte truncates the frame without an FCS.
      ST_SFD, ST_DATA: begin
        if (!dv) begin
          w_nextErr    = 1'b1;
          w_nextState  = ST_IFG;
          w_nextIfgCnt = '0;
        end else begin
          w_nextTxd     = d;
          w_nextTxen    = 1'b1;
          w_crcEn       = 1'b1;
          w_nextByteCnt = w_incCnt;
          w_nextState   = ST_DATA;
          if (last || w_forcedLast) begin
            w_nextErr    = w_forcedLast & ~last;
            w_nextFcsCnt = '0;
`ifdef ETH_TX_PAD_EN
            w_nextState  = (w_incCnt < 11'(MIN_PAYLOAD)) ? ST_PAD : ST_FCS;
`else
            w_nextState  = ST_FCS;
`endif
          end
        end
      end

`ifdef ETH_TX_PAD_EN
      ST_PAD: begin
        w_nextTxd     = 8'h00;
        w_nextTxen    = 1'b1;
        w_crcEn       = 1'b1;
        w_crcData     = 8'h00;
        w_nextByteCnt = w_incCnt;
        if (w_incCnt >= 11'(MIN_PAYLOAD)) begin
          w_nextState  = ST_FCS;
          w_nextFcsCnt = '0;
        end
      end
`endif

      ST_FCS: begin
        w_nextTxd    = w_fcsByte;
        w_nextTxen   = 1'b1;
        w_nextFcsCnt = r_fcsCnt + 2'd1;
        if (r_fcsCnt == 2'd3) begin
          w_nextState  = ST_IFG;
          w_nextIfgCnt = '0;
        end
      end

      ST_IFG: begin
        if (r_ifgCnt == IFG_LAST) begin
          w_nextState = ST_IDLE;
          w_nextBusy  = 1'b0;
        end else begin
          w_nextIfgCnt = r_ifgCnt + 1'b1;
        end
      end

      default: begin
        w_nextState = ST_IDLE;
        w_nextBusy  = 1'b0;
      end
    endcase

    w_nextRdy = (w_nextState == ST_SFD) || (w_nextState == ST_DATA);
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      r_state   <= ST_IDLE;
      r_preCnt  <= '0;
      r_byteCnt <= '0;
      r_fcsCnt  <= '0;
      r_ifgCnt  <= '0;
      txd       <= 8'h00;
      txen      <= 1'b0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_preCnt  <= w_nextPreCnt;
      r_byteCnt <= w_nextByteCnt;
      r_fcsCnt  <= w_nextFcsCnt;
      r_ifgCnt  <= w_nextIfgCnt;
      txd       <= w_nextTxd;
      txen      <= w_nextTxen;
      rdy       <= w_nextRdy;
      busy      <= w_nextBusy;
      err       <= w_nextErr;
    end
  end

endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-wide Ethernet transmit framer between the packet-assembly logic and the MII/RMII byte serializer of the motor-controller FPGA. It accepts a payload stream over a ready/valid handshake and emits preamble, SFD, payload, optional minimum-length padding and the IEEE 802.3 FCS. It then enforces the inter-frame gap. FCS generation is internal, so the serializer receives a complete wire-ready frame.

## Interface
- IFG_CYCLES, 12: idle byte-times enforced after each frame (minimum 1).
- MAX_LEN, 1514: payload byte limit. The byte accepted while the count equals MAX_LEN-1 is forced to be treated as last.
- c  in  1  clock, one byte-time per cycle.
- r  in  1  reset, asynchronous, active-high.
- d  in  8  payload byte.
- dv  in  1  payload byte valid.
- last  in  1  qualifies the final payload byte; sampled with dv.
- rdy  out  1  framer accepts d this cycle; a byte is taken when dv & rdy.
- txd  out  8  wire byte, registered.
- txen  out  1  wire byte valid, registered.
- busy  out  1  high from frame start to end of IFG.
- err  out  1  one-cycle pulse on underrun or overlength.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE → PRE when dv=1. The byte is not consumed; rdy=0 in IDLE.
- PRE: emit 0x55 for 7 cycles, then go to SFD.
- SFD: emit 0xD5 and assert rdy. The first payload byte is taken in this cycle.
- DATA: rdy=1. Each accepted byte goes to txd next cycle and into the CRC.
  - Accepting a byte with last, or the MAX_LEN-th byte, drops rdy next cycle.
  - It then goes to PAD if the count is below 60 and padding is compiled in; otherwise it goes to FCS.
- Underrun: rdy=1 and dv=0 in the SFD or DATA state.
  - Pulse err, drop txen next cycle (frame truncated, no FCS) and go to IFG.
- Overlength: the forced last at MAX_LEN also pulses err; the frame still completes normally with FCS.
- PAD: emit 0x00 and feed it to the CRC until the payload+pad count reaches 60.
- FCS: emit 4 bytes. Details:
  - CRC is the reflected CRC-32 (poly 0xEDB88320), initialised to 0xFFFFFFFF at SFD.
  - FCS = ~crc, sent byte [7:0] first, then [15:8], [23:16], [31:24].
- IFG: txen=0 and busy=1 for IFG_CYCLES cycles, then go to IDLE. dv is ignored.
- Byte counter is 11 bits and saturates at 2047.

## Timing
- Reset values: txd=0x00, txen=0, rdy=0, busy=0, err=0, state IDLE, CRC 0xFFFFFFFF.
- Asserting r mid-frame forces txen low immediately (asynchronous). No partial FCS is emitted.
- Start latency: dv first high at cycle 0. Preamble appears on txd/txen at cycles 1–7, SFD at cycle 8.
- Payload: the first byte is accepted at cycle 8 and appears at cycle 9.
- Data path latency is one cycle from acceptance to txd.
- For N payload bytes: txen high for 8 + max(N, 60) + 4 cycles with padding, or 8 + N + 4 without.
  - It is continuous, with no gaps.
- busy rises the cycle after dv is sampled in IDLE. It falls the cycle the IFG ends; back-to-back frames are separated by exactly IFG_CYCLES low txen cycles.
- rdy is a registered function of state. It never depends combinationally on dv.

## Configuration
- ETH_TX_PAD_EN defined: frames shorter than 60 payload bytes are zero-padded to 60 before the FCS.
- ETH_TX_PAD_EN undefined: the PAD state and comparator are removed, and the FCS follows the last payload byte directly. Upstream is then responsible for minimum length.

## Structure
- Package eth_pkg holds:
  - the state enum;
  - preamble 0x55, SFD 0xD5 and CRC seed/poly constants;
  - the minimum-payload constant 60.
- Sub-module eth_fcs_lfsr: registered byte-wide reflected CRC-32 update. Ports: c, r, init, en, d[7:0], crc[31:0]. crc is valid the cycle after en.
- The framer owns the state machine, counters and output mux.

## Test plan
- Padding undefined, payload ASCII "123456789" → txd = 7×0x55, 0xD5, 31..39, then 0x26 0x39 0xF4 0xCB. txen high 21 cycles.
- Padding defined, 9-byte payload → 51 bytes of 0x00 after the payload. The FCS matches the golden CRC-32 over 60 bytes. txen high 72 cycles.
- Two back-to-back 64-byte frames with dv held high → exactly 12 txen-low cycles between them. The second preamble starts on the 13th cycle.
- dv dropped after 20 payload bytes → err pulses once, txen falls after byte 20 (no FCS), then 12 IFG cycles and IDLE.
- 1600-byte stream with no last → the byte at 1514 is forced last and err pulses. A valid FCS follows; rdy stays low until IDLE.
- r asserted during the FCS state → txen=0 and busy=0 asynchronously. The next frame starts with a fresh preamble and correct CRC.
